// File: rtl/alu_pkg.sv
// Shared definitions for the ALU scheduler: op encodings, default width and
// the per-requester slot state.
package alu_pkg;

    localparam int ALU_W = 32;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        INFLIGHT = 2'b01,
        FULL     = 2'b10
    } slot_state_e;

endpackage

// File: rtl/alu_sched_rr_arbiter.sv
// Round-robin arbiter: picks one eligible requester per cycle, starting the
// search just after the most recent winner.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] eligible_i,
    output logic [N-1:0] grant_o
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] last_grant_q;
    logic [IW-1:0] last_grant_d;
    logic [IW-1:0] cand_s;
    logic [N-1:0]  grant_d;
    logic          found_s;

    // Scan eligible requesters from last_grant+1 with wrap; first hit wins.
    always_comb begin
        grant_d      = '0;
        last_grant_d = last_grant_q;
        found_s      = 1'b0;
        cand_s       = '0;
        for (int off = 1; off <= N; off++) begin
            cand_s = IW'((int'(last_grant_q) + off) % N);
            if (!found_s && eligible_i[cand_s]) begin
                grant_d[cand_s] = 1'b1;
                last_grant_d    = cand_s;
                found_s         = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Pointer moves only when someone is granted; N-1 after reset gives 0 priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= IW'(N - 1);
        end else if (found_s) begin
            last_grant_q <= last_grant_d;
        end else begin
            last_grant_q <= last_grant_q;
        end
    end

    assign grant_o = grant_d;

endmodule

// File: rtl/alu_sched.sv
// Shares one registered ALU between N requesters; each requester owns a
// one-entry result slot that is refilled the cycle after its op is issued.
module alu_sched
    import alu_pkg::*;
#(
    parameter int N = 2,
    parameter int W = ALU_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req_valid,
    output logic [N-1:0]   req_ready,
    input  logic [N*W-1:0] req_a,
    input  logic [N*W-1:0] req_b,
    input  logic [N*2-1:0] req_op,
    output logic [N-1:0]   rsp_valid,
    input  logic [N-1:0]   rsp_ready,
    output logic [N*W-1:0] rsp_s,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic [1:0]     alu_op,
    input  logic [W-1:0]   alu_s
);

    slot_state_e  slot_q [N];
    slot_state_e  slot_d [N];
    logic [W-1:0] rsp_q  [N];
    logic [W-1:0] rsp_d  [N];
    logic [N-1:0] eligible_s;
    logic [N-1:0] grant_s;

    // A slot can take a new op when empty, or when full and being drained now.
    always_comb begin
        eligible_s = '0;
        for (int i = 0; i < N; i++) begin
            eligible_s[i] = rst_n & req_valid[i] &
                            ((slot_q[i] == IDLE) | ((slot_q[i] == FULL) & rsp_ready[i]));
        end
    end

    rr_arbiter #(.N(N)) u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .eligible_i (eligible_s),
        .grant_o    (grant_s)
    );

    assign req_ready = grant_s;

    // Grant is one-hot or zero, so an AND-OR mux yields zero when idle.
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = 2'b00;
        for (int i = 0; i < N; i++) begin
            alu_a  = alu_a  | (req_a[i*W +: W]  & {W{grant_s[i]}});
            alu_b  = alu_b  | (req_b[i*W +: W]  & {W{grant_s[i]}});
            alu_op = alu_op | (req_op[i*2 +: 2] & {2{grant_s[i]}});
        end
    end

    // Slot transitions; the ALU result is captured on the INFLIGHT edge.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            slot_d[i] = slot_q[i];
            rsp_d[i]  = rsp_q[i];
            case (slot_q[i])
                IDLE: begin
                    if (grant_s[i]) begin
                        slot_d[i] = INFLIGHT;
                    end else begin
                        slot_d[i] = IDLE;
                    end
                end
                INFLIGHT: begin
                    slot_d[i] = FULL;
                    rsp_d[i]  = alu_s;
                end
                FULL: begin
                    if (rsp_ready[i] && grant_s[i]) begin
                        slot_d[i] = INFLIGHT;
                    end else if (rsp_ready[i]) begin
                        slot_d[i] = IDLE;
                    end else begin
                        slot_d[i] = FULL;
                    end
                end
                default: begin
                    slot_d[i] = IDLE;
                end
            endcase
        end
    end

    // Slot state and held results; reset drops any op still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                slot_q[i] <= IDLE;
                rsp_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                slot_q[i] <= slot_d[i];
                rsp_q[i]  <= rsp_d[i];
            end
        end
    end

    // Flatten per-requester results onto the packed response ports.
    always_comb begin
        rsp_valid = '0;
        rsp_s     = '0;
        for (int i = 0; i < N; i++) begin
            rsp_valid[i]     = (slot_q[i] == FULL);
            rsp_s[i*W +: W]  = rsp_q[i];
        end
    end

endmodule
